// File: rtl/remote_encoder_if.sv
// Symbol handshake and serial line bundle for the remote-line encoder.
// The source drives din/valid and watches ready; the encoder drives the
// serial line (dout) and the end-of-frame pulse (done).
interface remote_encoder_if;
    logic [3:0] din;
    logic       valid;
    logic       ready;
    logic       dout;
    logic       done;

    modport master (
        output din,
        output valid,
        input  ready,
        input  dout,
        input  done
    );

    modport slave (
        input  din,
        input  valid,
        output ready,
        output dout,
        output done
    );
endinterface

// File: rtl/remote_encoder.sv
// Remote-line encoder: serialises a 4-bit symbol as an 8-bit frame
// (header 1,0,1,0 then the symbol MSB first), each bit held BIT_CYCLES
// clocks, followed by GAP_BITS idle-low bit periods before the next
// symbol may be accepted. All outputs come straight from flops.
module remote_encoder #(
    parameter int BIT_CYCLES = 1,
    parameter int GAP_BITS   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    remote_encoder_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2,
        GAP    = 2'd3
    } state_t;

    localparam logic [7:0] BIT_LAST = 8'(BIT_CYCLES - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

    // Header pattern: even positions are 1, odd positions are 0.
    function automatic logic header_bit(input logic [2:0] idx);
        logic b;
        case (idx)
            3'd0:    b = 1'b1;
            3'd1:    b = 1'b0;
            3'd2:    b = 1'b1;
            3'd3:    b = 1'b0;
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    // Payload bit at position idx, sent MSB first.
    function automatic logic data_bit(input logic [3:0] sym, input logic [2:0] idx);
        logic b;
        case (idx)
            3'd0:    b = sym[3];
            3'd1:    b = sym[2];
            3'd2:    b = sym[1];
            3'd3:    b = sym[0];
            default: b = 1'b0;
        endcase
        return b;
    endfunction

    state_t     state_r,   state_s;
    logic [2:0] bit_cnt_r, bit_cnt_s;
    logic [7:0] cyc_cnt_r, cyc_cnt_s;
    logic [3:0] gap_cnt_r, gap_cnt_s;
    logic [3:0] sym_r,     sym_s;
    logic       dout_r,    dout_s;
    logic       ready_r,   ready_s;
    logic       done_r,    done_s;

    logic       bit_end_s;
    logic [2:0] bit_nxt_s;

    assign bit_end_s = (cyc_cnt_r == BIT_LAST);
    assign bit_nxt_s = bit_cnt_r + 3'd1;

    assign bus.dout  = dout_r;
    assign bus.ready = ready_r;
    assign bus.done  = done_r;

    // State, counters, captured symbol and output flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            bit_cnt_r <= 3'd0;
            cyc_cnt_r <= 8'd0;
            gap_cnt_r <= 4'd0;
            sym_r     <= 4'd0;
            dout_r    <= 1'b0;
            ready_r   <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_s;
            bit_cnt_r <= bit_cnt_s;
            cyc_cnt_r <= cyc_cnt_s;
            gap_cnt_r <= gap_cnt_s;
            sym_r     <= sym_s;
            dout_r    <= dout_s;
            ready_r   <= ready_s;
            done_r    <= done_s;
        end
    end

    // Next-state and next-output decode; done defaults low so it pulses once.
    always_comb begin
        state_s   = state_r;
        bit_cnt_s = bit_cnt_r;
        cyc_cnt_s = cyc_cnt_r;
        gap_cnt_s = gap_cnt_r;
        sym_s     = sym_r;
        dout_s    = dout_r;
        ready_s   = ready_r;
        done_s    = 1'b0;

        case (state_r)
            IDLE: begin
                if (bus.valid && ready_r) begin
                    // Accept: first header bit goes out on this same edge.
                    sym_s     = bus.din;
                    ready_s   = 1'b0;
                    dout_s    = header_bit(3'd0);
                    bit_cnt_s = 3'd0;
                    cyc_cnt_s = 8'd0;
                    state_s   = HEADER;
                end else begin
                    // Also raises ready on the first edge after reset.
                    ready_s   = 1'b1;
                    dout_s    = 1'b0;
                end
            end

            HEADER: begin
                if (bit_end_s) begin
                    cyc_cnt_s = 8'd0;
                    if (bit_cnt_r == 3'd3) begin
                        bit_cnt_s = 3'd0;
                        dout_s    = data_bit(sym_r, 3'd0);
                        state_s   = DATA;
                    end else begin
                        bit_cnt_s = bit_nxt_s;
                        dout_s    = header_bit(bit_nxt_s);
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + 8'd1;
                end
            end

            DATA: begin
                if (bit_end_s) begin
                    cyc_cnt_s = 8'd0;
                    if (bit_cnt_r == 3'd3) begin
                        bit_cnt_s = 3'd0;
                        gap_cnt_s = 4'd0;
                        dout_s    = 1'b0;
                        done_s    = 1'b1;
                        state_s   = GAP;
                    end else begin
                        bit_cnt_s = bit_nxt_s;
                        dout_s    = data_bit(sym_r, bit_nxt_s);
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + 8'd1;
                end
            end

            GAP: begin
                if (bit_end_s) begin
                    cyc_cnt_s = 8'd0;
                    if (gap_cnt_r == GAP_LAST) begin
                        gap_cnt_s = 4'd0;
                        ready_s   = 1'b1;
                        state_s   = IDLE;
                    end else begin
                        gap_cnt_s = gap_cnt_r + 4'd1;
                    end
                end else begin
                    cyc_cnt_s = cyc_cnt_r + 8'd1;
                end
            end

            default: begin
                state_s = IDLE;
                dout_s  = 1'b0;
                ready_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_remote_encoder.sv
// Self-checking bench for remote_encoder. Two instances share stimulus:
// BIT_CYCLES=1 and BIT_CYCLES=3, both with GAP_BITS=2. A scoreboard entry
// (acceptance edge, symbol) is pushed when the bench's own ready model says
// the symbol is taken, and the expected dout/ready/done are rebuilt from it
// every cycle until the entry is retired when ready is due back.
module tb_remote_encoder;

    localparam int GAP  = 2;
    localparam int BC_A = 1;
    localparam int BC_B = 3;

    typedef struct {
        int         k;
        logic [3:0] sym;
    } frame_t;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b1;
    logic [3:0] tb_din = 4'd0;
    logic       tb_valid = 1'b0;

    frame_t sb_a[$];
    frame_t sb_b[$];
    bit     mrdy_a = 1'b0;
    bit     mrdy_b = 1'b0;
    bit     in_rst = 1'b1;
    int     cyc    = 0;
    int     n_checks = 0;
    int     n_fails  = 0;

    remote_encoder_if if_a ();
    remote_encoder_if if_b ();

    assign if_a.din   = tb_din;
    assign if_a.valid = tb_valid;
    assign if_b.din   = tb_din;
    assign if_b.valid = tb_valid;

    remote_encoder #(.BIT_CYCLES(BC_A), .GAP_BITS(GAP)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_a.slave)
    );

    remote_encoder #(.BIT_CYCLES(BC_B), .GAP_BITS(GAP)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_b.slave)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, act, exp);
        end
    endtask

    // Expected {dout, ready, done} after edge e for a frame accepted at edge f.k.
    function automatic logic [2:0] expect_out(input bit act, input frame_t f, input int bc,
                                              input int e, input bit mrdy);
        int         rel;
        logic [7:0] frame;
        if (!act) return {1'b0, mrdy, 1'b0};
        rel   = e - f.k;
        frame = {4'b1010, f.sym};
        if (rel < 8 * bc)          return {frame[7 - rel / bc], 2'b00};
        if (rel == 8 * bc)         return 3'b001;
        if (rel < (8 + GAP) * bc)  return 3'b000;
        return 3'b010;
    endfunction

    task automatic check_all();
        frame_t     h;
        logic [2:0] ex;
        bit         act;
        // instance A
        act = (sb_a.size() > 0);
        h.k = 0; h.sym = 4'd0;
        if (act) h = sb_a[0];
        ex = expect_out(act, h, BC_A, cyc, mrdy_a);
        check_val("a_dout",  {31'd0, if_a.dout},  {29'd0, ex[2]});
        check_val("a_ready", {31'd0, if_a.ready}, {29'd0, ex[1]});
        check_val("a_done",  {31'd0, if_a.done},  {29'd0, ex[0]});
        if (act && (cyc - h.k) == (8 + GAP) * BC_A) begin
            void'(sb_a.pop_front());
            mrdy_a = 1'b1;
        end
        // instance B
        act = (sb_b.size() > 0);
        h.k = 0; h.sym = 4'd0;
        if (act) h = sb_b[0];
        ex = expect_out(act, h, BC_B, cyc, mrdy_b);
        check_val("b_dout",  {31'd0, if_b.dout},  {29'd0, ex[2]});
        check_val("b_ready", {31'd0, if_b.ready}, {29'd0, ex[1]});
        check_val("b_done",  {31'd0, if_b.done},  {29'd0, ex[0]});
        if (act && (cyc - h.k) == (8 + GAP) * BC_B) begin
            void'(sb_b.pop_front());
            mrdy_b = 1'b1;
        end
    endtask

    // Drive one cycle of stimulus, advance the model at the edge, check at negedge.
    task automatic tick(input logic [3:0] d, input logic v);
        frame_t f;
        tb_din   = d;
        tb_valid = v;
        @(posedge clk);
        cyc++;
        if (!in_rst) begin
            f.k = cyc; f.sym = d;
            if (v && mrdy_a) begin
                sb_a.push_back(f);
                mrdy_a = 1'b0;
            end else if (sb_a.size() == 0) begin
                mrdy_a = 1'b1;
            end
            if (v && mrdy_b) begin
                sb_b.push_back(f);
                mrdy_b = 1'b0;
            end else if (sb_b.size() == 0) begin
                mrdy_b = 1'b1;
            end
        end
        @(negedge clk);
        check_all();
    endtask

    // Assert reset between edges, check outputs clear with no clock edge, release.
    task automatic do_reset();
        #2;
        rst_n  = 1'b0;
        in_rst = 1'b1;
        sb_a.delete();
        sb_b.delete();
        mrdy_a = 1'b0;
        mrdy_b = 1'b0;
        #1;
        check_val("rst_a_dout",  {31'd0, if_a.dout},  32'd0);
        check_val("rst_a_ready", {31'd0, if_a.ready}, 32'd0);
        check_val("rst_a_done",  {31'd0, if_a.done},  32'd0);
        check_val("rst_b_dout",  {31'd0, if_b.dout},  32'd0);
        check_val("rst_b_ready", {31'd0, if_b.ready}, 32'd0);
        check_val("rst_b_done",  {31'd0, if_b.done},  32'd0);
        @(negedge clk);
        tick(4'd0, 1'b0);
        tick(4'd5, 1'b1);
        rst_n  = 1'b1;
        in_rst = 1'b0;
        tick(4'd0, 1'b0);
    endtask

    task automatic send_one(input logic [3:0] d);
        tick(d, 1'b1);
        repeat (34) tick(4'($urandom), 1'b0);
    endtask

    initial begin
        do_reset();
        repeat (3) tick(4'd0, 1'b0);

        send_one(4'b1101);
        send_one(4'b0110);
        send_one(4'b0000);
        send_one(4'b1111);

        // valid held high with din changing every cycle
        for (int i = 0; i < 50; i++) tick(4'($urandom), 1'b1);
        repeat (35) tick(4'd0, 1'b0);

        // reset in the middle of instance A's DATA phase
        tick(4'b1010, 1'b1);
        repeat (5) tick(4'($urandom), 1'b0);
        do_reset();
        send_one(4'b1001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/remote_encoder.md
REMOTE_ENCODER -- requirements
Module: remote_encoder

Interface
REQ-001 Parameter: BIT_CYCLES, default 1, clock cycles each serial bit is held on dout (legal range 1..255).
REQ-002 Parameter: GAP_BITS, default 2, minimum idle-low bit periods after each frame (legal range 1..15).
REQ-003 Port: clk  input  1  system clock; all state changes on its rising edge.
REQ-004 Port: rst_n  input  1  reset, asynchronous and active-low.
REQ-005 Port: din  input  4  parallel symbol to transmit.
REQ-006 Port: valid  input  1  din holds a symbol to send.
REQ-007 Port: ready  output  1  encoder can accept a symbol this cycle.
REQ-008 Port: dout  output  1  serial remote-line output, idle low.
REQ-009 Port: done  output  1  one-cycle pulse marking the end of a frame's last bit.

Function
REQ-010 Frame format SHALL be 8 bits: header 1,0,1,0, then din[3], din[2], din[1], din[0] (MSB first).
REQ-011 Each frame bit SHALL be driven on dout for exactly BIT_CYCLES consecutive cycles.
REQ-012 dout, ready and done SHALL be registered outputs.
REQ-013 FSM states SHALL be IDLE, HEADER, DATA, GAP.
REQ-014 IDLE: dout=0, ready=1; on a rising edge with valid=1 and ready=1, capture din, ready<=0, dout<=1, go to HEADER.
REQ-015 HEADER -> DATA after the 4th header bit period; DATA -> GAP after the 4th data bit period.
REQ-016 The edge ending DATA SHALL set dout<=0 and done<=1; done SHALL fall on the next edge.
REQ-017 GAP: dout=0 for GAP_BITS*BIT_CYCLES cycles; the edge ending GAP SHALL set ready<=1 and go to IDLE.
REQ-018 Timing: acceptance at edge k -> dout=1 from edge k; frame occupies edges k..k+8*BIT_CYCLES; ready rises at edge k+(8+GAP_BITS)*BIT_CYCLES.
REQ-019 Minimum spacing between accepted symbols SHALL be (8+GAP_BITS)*BIT_CYCLES+1 cycles.
REQ-020 The captured symbol SHALL be immune to din/valid changes after acceptance.
REQ-021 valid while ready=0 SHALL be ignored (not queued); the source holds valid until the ready handshake.
REQ-022 Bit counter (3 bits) and cycle counter (8 bits) SHALL wrap internally without affecting outputs; no out-of-range counts are reachable.

Reset
REQ-023 rst_n=0 SHALL immediately force dout=0, ready=0, done=0, state IDLE, counters and symbol register cleared, regardless of clk.
REQ-024 ready SHALL rise on the first rising clk edge after rst_n returns high.
REQ-025 Reset during any state mid-frame SHALL abort the frame with no done pulse; the partial frame SHALL not resume.

Verification
REQ-026 BIT_CYCLES=1, GAP_BITS=2, din=4'b1101 with valid for one cycle -> dout 1,0,1,0,1,1,0,1 on 8 consecutive cycles, then 0; done high for 1 cycle; ready back 10 cycles after acceptance.
REQ-027 BIT_CYCLES=3, din=4'b0110 -> every bit held 3 cycles (24-cycle frame); ready returns 30 cycles after acceptance.
REQ-028 valid held continuously with din changing each cycle -> frames back-to-back 11 cycles apart (defaults), each carrying the din value present at its acceptance edge.
REQ-029 Assert rst_n=0 mid-way through the DATA state -> dout=0 and ready=0 without a clock edge; no done; ready=1 one edge after release; next frame is complete and correct.
REQ-030 din=4'b0000 and 4'b1111 -> header 1010 then 0000 / 1111; dout returns to 0 after each; no spurious done outside frame end.
